alu_seq_mult: RTL and testbench



---
 rtl/alu_seq_mult_if.sv | 22 ++
 rtl/alu_seq_mult.sv | 149 ++++++++++++++
 tb/tb_alu_seq_mult.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_mult_if.sv
// Start/busy/done handshake and operand/result bus between an issuing
// controller (master) and the sequential multiplier (slave).
interface alu_seq_mult_if #(
    parameter int n = 4
);
    logic           start;
    logic [n-1:0]   A;
    logic [n-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*n-1:0] Product;

    modport master (
        output start, A, B,
        input  busy, done, Product
    );

    modport slave (
        input  start, A, B,
        output busy, done, Product
    );
endinterface

// File: rtl/alu_seq_mult.sv
// Unsigned shift-add multiplier that sequences one ALU_nbit (held in ADD mode)
// over n iterations. Optional macro MULT_ZERO_SKIP_EN short-circuits zero operands.
module ALU_nbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [2:0]   Mode,
    input  logic         CB_in,
    output logic [n-1:0] Result,
    output logic         CB_out
);
    logic [n:0] sum_s;
    logic [n:0] diff_s;

    assign sum_s  = {1'b0, A} + {1'b0, B} + {{n{1'b0}}, CB_in};
    assign diff_s = {1'b0, A} - {1'b0, B} - {{n{1'b0}}, CB_in};

    // Mode decode; CB_out carries carry, borrow or the bit shifted out.
    always_comb begin
        Result = {n{1'b0}};
        CB_out = 1'b0;
        case (Mode)
            3'b000:  {CB_out, Result} = sum_s;
            3'b001:  {CB_out, Result} = diff_s;
            3'b010:  Result = A & B;
            3'b011:  Result = A | B;
            3'b100:  Result = A ^ B;
            3'b101:  Result = ~A;
            3'b110:  {CB_out, Result} = {A, 1'b0};
            3'b111:  {Result, CB_out} = {1'b0, A};
            default: begin
                Result = {n{1'b0}};
                CB_out = 1'b0;
            end
        endcase
    end
endmodule

module alu_seq_mult #(
    parameter int n = 4
) (
    input logic            clk,
    input logic            nrst,
    alu_seq_mult_if.slave  bus
);
    localparam int            CW       = $clog2(n) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CALC    = 2'b01,
        DONE_ST = 2'b10
    } state_t;

    state_t         state_r;
    logic [n-1:0]   m_r;
    logic [n-1:0]   p_hi_r;
    logic [n-1:0]   q_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r;
    logic           done_r;
    logic [2*n-1:0] product_r;

    logic [n-1:0]   alu_sum_s;
    logic           alu_carry_s;

    ALU_nbit #(.n(n)) u_alu (
        .A      (p_hi_r),
        .B      (m_r),
        .Mode   (3'b000),
        .CB_in  (1'b0),
        .Result (alu_sum_s),
        .CB_out (alu_carry_s)
    );

`ifdef MULT_ZERO_SKIP_EN
    logic zero_op_s;
    assign zero_op_s = (bus.A == {n{1'b0}}) || (bus.B == {n{1'b0}});
`endif

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.Product = product_r;

    // Control FSM and datapath; all outputs are registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r   <= IDLE;
            m_r       <= {n{1'b0}};
            p_hi_r    <= {n{1'b0}};
            q_r       <= {n{1'b0}};
            cnt_r     <= {CW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {(2*n){1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        m_r    <= bus.A;
                        q_r    <= bus.B;
                        p_hi_r <= {n{1'b0}};
                        cnt_r  <= {CW{1'b0}};
                        busy_r <= 1'b1;
`ifdef MULT_ZERO_SKIP_EN
                        // Zero operand: clear Q so DONE publishes a zero product.
                        if (zero_op_s) begin
                            q_r     <= {n{1'b0}};
                            state_r <= DONE_ST;
                        end else begin
                            state_r <= CALC;
                        end
`else
                        state_r <= CALC;
`endif
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                CALC: begin
                    // Carry lands in P_hi's MSB, so the 2n-bit product never overflows.
                    if (q_r[0]) begin
                        {p_hi_r, q_r} <= {alu_carry_s, alu_sum_s, q_r[n-1:1]};
                    end else begin
                        {p_hi_r, q_r} <= {1'b0, p_hi_r, q_r[n-1:1]};
                    end
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        state_r <= DONE_ST;
                    end else begin
                        state_r <= CALC;
                    end
                end
                DONE_ST: begin
                    product_r <= {p_hi_r, q_r};
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_mult.sv
// Directed self-checking bench for alu_seq_mult at n=4 and n=8, with
// hand-computed products and exact done-pulse latency.
module tb_alu_seq_mult;
    logic clk = 1'b0;
    logic nrst4;
    logic nrst8;
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

`ifdef MULT_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 5;
`endif

    alu_seq_mult_if #(.n(4)) bus4 ();
    alu_seq_mult_if #(.n(8)) bus8 ();

    alu_seq_mult #(.n(4)) dut4 (.clk(clk), .nrst(nrst4), .bus(bus4));
    alu_seq_mult #(.n(8)) dut8 (.clk(clk), .nrst(nrst8), .bus(bus8));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp_p,
                       input int lat, input string tag);
        bus4.A = a;
        bus4.B = b;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        for (int k = 0; k < lat; k++) begin
            chk1({tag, "_busy"}, bus4.busy, 1'b1);
            chk1({tag, "_nodone"}, bus4.done, 1'b0);
            tick();
        end
        chk1({tag, "_done"}, bus4.done, 1'b1);
        chk1({tag, "_idle"}, bus4.busy, 1'b0);
        chk16({tag, "_prod"}, 16'(bus4.Product), 16'(exp_p));
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p,
                       input int lat, input string tag);
        bus8.A = a;
        bus8.B = b;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        for (int k = 0; k < lat; k++) begin
            chk1({tag, "_busy"}, bus8.busy, 1'b1);
            chk1({tag, "_nodone"}, bus8.done, 1'b0);
            tick();
        end
        chk1({tag, "_done"}, bus8.done, 1'b1);
        chk1({tag, "_idle"}, bus8.busy, 1'b0);
        chk16({tag, "_prod"}, bus8.Product, exp_p);
    endtask

    initial begin
        // Reset held for two edges with start asserted.
        nrst4 = 1'b0;
        nrst8 = 1'b0;
        bus4.start = 1'b1;
        bus4.A = 4'd13;
        bus4.B = 4'd11;
        bus8.start = 1'b1;
        bus8.A = 8'd255;
        bus8.B = 8'd255;
        tick();
        tick();
        chk1("rst_busy", bus4.busy, 1'b0);
        chk1("rst_done", bus4.done, 1'b0);
        chk16("rst_prod", 16'(bus4.Product), 16'd0);
        chk1("rst8_busy", bus8.busy, 1'b0);
        chk16("rst8_prod", bus8.Product, 16'd0);
        bus4.start = 1'b0;
        bus8.start = 1'b0;
        nrst4 = 1'b1;
        nrst8 = 1'b1;
        tick();
        chk1("post_rst_busy", bus4.busy, 1'b0);
        chk1("post_rst_done", bus4.done, 1'b0);

        op4(4'd13, 4'd11, 8'd143, 5, "m13x11");
        tick();
        chk1("m13x11_pulse", bus4.done, 1'b0);
        chk16("m13x11_hold", 16'(bus4.Product), 16'd143);

        op4(4'd15, 4'd15, 8'd225, 5, "m15x15");
        tick();
        op4(4'd0, 4'd9, 8'd0, ZLAT, "m0x9");
        tick();

        // 6*7 accepted; a second start during CALC must be ignored.
        bus4.A = 4'd6;
        bus4.B = 4'd7;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        chk1("ign_busy0", bus4.busy, 1'b1);
        tick();
        chk1("ign_busy1", bus4.busy, 1'b1);
        bus4.A = 4'd2;
        bus4.B = 4'd2;
        bus4.start = 1'b1;
        tick();
        chk1("ign_nodone2", bus4.done, 1'b0);
        tick();
        chk1("ign_nodone3", bus4.done, 1'b0);
        bus4.start = 1'b0;
        tick();
        chk1("ign_busy4", bus4.busy, 1'b1);
        chk1("ign_nodone4", bus4.done, 1'b0);
        tick();
        chk1("ign_done", bus4.done, 1'b1);
        chk16("ign_prod", 16'(bus4.Product), 16'd42);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("ign_single_done", bus4.done, 1'b0);
            chk1("ign_no_requeue", bus4.busy, 1'b0);
            chk16("ign_hold", 16'(bus4.Product), 16'd42);
        end

        // 9*5 aborted by reset at the third edge after acceptance.
        bus4.A = 4'd9;
        bus4.B = 4'd5;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        tick();
        tick();
        nrst4 = 1'b0;
        tick();
        chk1("abort_busy", bus4.busy, 1'b0);
        chk1("abort_done", bus4.done, 1'b0);
        chk16("abort_prod", 16'(bus4.Product), 16'd0);
        nrst4 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk1("abort_no_done", bus4.done, 1'b0);
        end
        op4(4'd3, 4'd5, 8'd15, 5, "m3x5");

        // n=8: max operands, then back-to-back start in the done cycle.
        op8(8'd255, 8'd255, 16'hFE01, 9, "m255x255");
        op8(8'd2, 8'd128, 16'd256, 9, "b2b_2x128");
        tick();
        chk1("b2b_pulse", bus8.done, 1'b0);
        chk16("b2b_hold", bus8.Product, 16'd256);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
